// File: rtl/change_dispenser.sv
// -----------------------------------------------------------------------------
// change_dispenser
//
// Returns change as quarters, dimes and nickels. A request is taken in IDLE,
// coins are released one per accepted cycle of the coin mechanism using a
// greedy largest-coin-first choice, and the request ends with a single-cycle
// done pulse. Each coin kind has its own 8-bit inventory. An inventory is
// loaded to INV_MAX on reset, and again on refill.
//
// Parameters
//   INV_MAX     : coins held by each inventory after reset or refill (1..255)
//
// Ports
//   clk         : single clock, rising-edge active
//   reset_n     : asynchronous active-low reset
//   start       : request to dispense 'amount', sampled only in IDLE
//   amount      : change to return in cents (0..511), unsigned
//   disp_ready  : coin mechanism can accept a coin this cycle
//   refill      : reload all inventories to INV_MAX, honoured only in IDLE
//   quarter_out : one-cycle pulse releasing one quarter
//   dime_out    : one-cycle pulse releasing one dime
//   nickel_out  : one-cycle pulse releasing one nickel
//   busy        : high whenever the controller is not in IDLE
//   done        : one-cycle pulse at the end of every accepted request
//   err         : last request failed; held until the next accepted start
//   remaining   : cents not yet dispensed
// -----------------------------------------------------------------------------
module change_dispenser #(
  parameter int unsigned INV_MAX = 20
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  input  logic [8:0] amount,
  input  logic       disp_ready,
  input  logic       refill,
  output logic       quarter_out,
  output logic       dime_out,
  output logic       nickel_out,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [8:0] remaining
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DISP = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [7:0] INV_INIT = 8'(INV_MAX);

  localparam logic [8:0] QUARTER_C = 9'd25;
  localparam logic [8:0] DIME_C    = 9'd10;
  localparam logic [8:0] NICKEL_C  = 9'd5;

  // Only whole nickels can be paid out; anything else is rejected up front.
  function automatic logic is_payable(input logic [8:0] cents);
    is_payable = ((cents % 9'd5) == 9'd0);
  endfunction

  // Registered state
  state_t     state_r;
  logic [8:0] rem_r;
  logic [7:0] inv_q_r;
  logic [7:0] inv_d_r;
  logic [7:0] inv_n_r;
  logic       q_out_r;
  logic       d_out_r;
  logic       n_out_r;
  logic       busy_r;
  logic       done_r;
  logic       err_r;

  // Next-state values
  state_t     state_s;
  logic [8:0] rem_s;
  logic [7:0] inv_q_s;
  logic [7:0] inv_d_s;
  logic [7:0] inv_n_s;
  logic       q_out_s;
  logic       d_out_s;
  logic       n_out_s;
  logic       busy_s;
  logic       done_s;
  logic       err_s;

  // Next-state, inventory and coin-selection logic
  always_comb begin
    state_s = state_r;
    rem_s   = rem_r;
    inv_q_s = inv_q_r;
    inv_d_s = inv_d_r;
    inv_n_s = inv_n_r;
    err_s   = err_r;
    q_out_s = 1'b0;
    d_out_s = 1'b0;
    n_out_s = 1'b0;

    case (state_r)
      IDLE: begin
        // Refill and start may land on the same edge; the request then
        // dispenses from the refilled stock because DISP starts next cycle.
        if (refill) begin
          inv_q_s = INV_INIT;
          inv_d_s = INV_INIT;
          inv_n_s = INV_INIT;
        end else begin
          inv_q_s = inv_q_r;
        end
        if (start) begin
          rem_s = amount;
          if (is_payable(amount)) begin
            err_s   = 1'b0;
            state_s = DISP;
          end else begin
            err_s   = 1'b1;
            state_s = DONE;
          end
        end else begin
          state_s = IDLE;
        end
      end

      DISP: begin
        if (rem_r == 9'd0) begin
          state_s = DONE;
        end else if (disp_ready) begin
          // Greedy with no backtracking: a fault is reported even when a
          // different coin mix could have paid the amount.
          if ((rem_r >= QUARTER_C) && (inv_q_r != 8'd0)) begin
            q_out_s = 1'b1;
            rem_s   = rem_r - QUARTER_C;
            inv_q_s = inv_q_r - 8'd1;
          end else if ((rem_r >= DIME_C) && (inv_d_r != 8'd0)) begin
            d_out_s = 1'b1;
            rem_s   = rem_r - DIME_C;
            inv_d_s = inv_d_r - 8'd1;
          end else if ((rem_r >= NICKEL_C) && (inv_n_r != 8'd0)) begin
            n_out_s = 1'b1;
            rem_s   = rem_r - NICKEL_C;
            inv_n_s = inv_n_r - 8'd1;
          end else begin
            // Out of usable coins: remaining stays at the unpaid value.
            err_s   = 1'b1;
            state_s = DONE;
          end
        end else begin
          state_s = DISP;
        end
      end

      DONE: begin
        state_s = IDLE;
      end

      default: begin
        state_s = IDLE;
      end
    endcase

    // Status outputs are registered from the state being entered so they
    // line up exactly with the state register.
    busy_s = (state_s != IDLE);
    done_s = (state_s == DONE);
  end

  // State, datapath and registered output flops
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= IDLE;
      rem_r   <= 9'd0;
      inv_q_r <= INV_INIT;
      inv_d_r <= INV_INIT;
      inv_n_r <= INV_INIT;
      q_out_r <= 1'b0;
      d_out_r <= 1'b0;
      n_out_r <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      err_r   <= 1'b0;
    end else begin
      state_r <= state_s;
      rem_r   <= rem_s;
      inv_q_r <= inv_q_s;
      inv_d_r <= inv_d_s;
      inv_n_r <= inv_n_s;
      q_out_r <= q_out_s;
      d_out_r <= d_out_s;
      n_out_r <= n_out_s;
      busy_r  <= busy_s;
      done_r  <= done_s;
      err_r   <= err_s;
    end
  end

  assign quarter_out = q_out_r;
  assign dime_out    = d_out_r;
  assign nickel_out  = n_out_r;
  assign busy        = busy_r;
  assign done        = done_r;
  assign err         = err_r;
  assign remaining   = rem_r;

endmodule

// File: tb/tb_change_dispenser.sv
// -----------------------------------------------------------------------------
// tb_change_dispenser
//
// Two instances: dut0 with the default stock of 20 per coin kind and dut1 with
// a stock of 1, so inventory exhaustion and refill are reachable quickly.
// Requests come from a table of vectors with hand-computed coin counts, final
// err/remaining and start-to-done latency; reset behaviour is exercised by a
// hand-written sequence.
// -----------------------------------------------------------------------------
module tb_change_dispenser;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       disp_ready = 1'b0;
  logic [8:0] amount = 9'd0;
  logic       start0 = 1'b0;
  logic       start1 = 1'b0;
  logic       refill0 = 1'b0;
  logic       refill1 = 1'b0;

  logic       q0, d0, n0, busy0, done0, err0;
  logic       q1, d1, n1, busy1, done1, err1;
  logic [8:0] rem0, rem1;

  change_dispenser #(.INV_MAX(20)) dut0 (
    .clk(clk), .reset_n(reset_n), .start(start0), .amount(amount),
    .disp_ready(disp_ready), .refill(refill0),
    .quarter_out(q0), .dime_out(d0), .nickel_out(n0),
    .busy(busy0), .done(done0), .err(err0), .remaining(rem0)
  );

  change_dispenser #(.INV_MAX(1)) dut1 (
    .clk(clk), .reset_n(reset_n), .start(start1), .amount(amount),
    .disp_ready(disp_ready), .refill(refill1),
    .quarter_out(q1), .dime_out(d1), .nickel_out(n1),
    .busy(busy1), .done(done1), .err(err1), .remaining(rem1)
  );

  always #5 clk = ~clk;

  // Selected instance's outputs
  logic       cur = 1'b0;
  logic       sq, sd, sn, sbusy, sdone, serr;
  logic [8:0] srem;
  assign sq    = cur ? q1    : q0;
  assign sd    = cur ? d1    : d0;
  assign sn    = cur ? n1    : n0;
  assign sbusy = cur ? busy1 : busy0;
  assign sdone = cur ? done1 : done0;
  assign serr  = cur ? err1  : err0;
  assign srem  = cur ? rem1  : rem0;

  typedef struct {
    bit sel;    // 0: dut0 (stock 20), 1: dut1 (stock 1)
    int amt;
    bit rf;     // refill together with start
    bit tog;    // toggle disp_ready every cycle
    bit poke;   // pulse start(amount=200)+refill while busy
    int eq, ed, en, eerr, erem, elat;  // elat=0: latency not checked
  } vec_t;

  vec_t vecs[15];
  int passed = 0;
  int total  = 0;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int nq, nd, nn, lat, multi, badrdy, got_err, got_rem;
    bit got, rdy_edge;
    nq = 0; nd = 0; nn = 0; lat = 0; multi = 0; badrdy = 0;
    got = 1'b0; got_err = -1; got_rem = -1;
    cur = v.sel;
    @(negedge clk);
    amount = v.amt[8:0];
    disp_ready = 1'b1;
    if (v.sel) begin start1 = 1'b1; refill1 = v.rf; end
    else       begin start0 = 1'b1; refill0 = v.rf; end
    while (!got && lat < 200) begin
      @(posedge clk);
      rdy_edge = disp_ready;
      @(negedge clk);
      lat++;
      start0 = 1'b0; start1 = 1'b0; refill0 = 1'b0; refill1 = 1'b0;
      if (v.poke && lat == 1) begin
        amount = 9'd200;
        if (v.sel) begin start1 = 1'b1; refill1 = 1'b1; end
        else       begin start0 = 1'b1; refill0 = 1'b1; end
      end
      if ((int'(sq) + int'(sd) + int'(sn)) > 1) multi++;
      if ((sq || sd || sn) && !rdy_edge) badrdy++;
      if (sq) nq++;
      if (sd) nd++;
      if (sn) nn++;
      if (sdone) begin
        got = 1'b1;
        got_err = int'(serr);
        got_rem = int'(srem);
      end else if (v.tog) begin
        disp_ready = ~disp_ready;
      end
    end
    chk({tag, "_done_seen"}, int'(got), 1);
    chk({tag, "_quarters"}, nq, v.eq);
    chk({tag, "_dimes"}, nd, v.ed);
    chk({tag, "_nickels"}, nn, v.en);
    chk({tag, "_err"}, got_err, v.eerr);
    chk({tag, "_remaining"}, got_rem, v.erem);
    chk({tag, "_one_coin_max"}, multi, 0);
    chk({tag, "_coin_needs_ready"}, badrdy, 0);
    if (v.elat != 0) chk({tag, "_latency"}, lat, v.elat);
    // done must drop after one cycle, busy clears, err/remaining held
    @(posedge clk);
    @(negedge clk);
    chk({tag, "_done_one_cycle"}, int'(sdone), 0);
    chk({tag, "_idle_not_busy"}, int'(sbusy), 0);
    chk({tag, "_err_held"}, int'(serr), v.eerr);
    chk({tag, "_rem_held"}, int'(srem), v.erem);
    disp_ready = 1'b1;
  endtask

  initial begin
    int nq, cyc, stray;
    vec_t after_rst;

    //          sel  amt  rf tog poke  q   d   n  err rem lat
    // dut0 stock 20/20/20; inventory carried between rows
    vecs[0]  = '{1'b0, 100, 1'b0, 1'b0, 1'b0,  4,  0,  0, 0,   0,  6};
    vecs[1]  = '{1'b0,  40, 1'b0, 1'b1, 1'b0,  1,  1,  1, 0,   0,  0};
    vecs[2]  = '{1'b0,  47, 1'b0, 1'b0, 1'b0,  0,  0,  0, 1,  47,  1};
    vecs[3]  = '{1'b0,   0, 1'b0, 1'b0, 1'b0,  0,  0,  0, 0,   0,  2};
    vecs[4]  = '{1'b0,  85, 1'b0, 1'b0, 1'b0,  3,  1,  0, 0,   0,  6};
    vecs[5]  = '{1'b0,  15, 1'b0, 1'b0, 1'b0,  0,  1,  1, 0,   0,  4};
    vecs[6]  = '{1'b0, 511, 1'b0, 1'b0, 1'b0,  0,  0,  0, 1, 511,  1};
    // stock now q12 d17 n18: drain quarters and dimes
    vecs[7]  = '{1'b0, 505, 1'b0, 1'b0, 1'b0, 12, 17,  7, 0,   0, 38};
    // stock q0 d0 n11: eleven nickels then fault with 5 left
    vecs[8]  = '{1'b0,  60, 1'b0, 1'b0, 1'b0,  0,  0, 11, 1,   5, 13};
    vecs[9]  = '{1'b0,  30, 1'b1, 1'b0, 1'b0,  1,  0,  1, 0,   0,  4};
    vecs[10] = '{1'b0,  50, 1'b0, 1'b0, 1'b1,  2,  0,  0, 0,   0,  4};
    // dut1 stock 1/1/1
    vecs[11] = '{1'b1,   5, 1'b0, 1'b0, 1'b0,  0,  0,  1, 0,   0,  3};
    // no nickels left: quarter then fault, no backtracking
    vecs[12] = '{1'b1,  30, 1'b0, 1'b0, 1'b0,  1,  0,  0, 1,   5,  3};
    vecs[13] = '{1'b1,  65, 1'b1, 1'b0, 1'b0,  1,  1,  1, 1,  25,  5};
    vecs[14] = '{1'b1,  25, 1'b1, 1'b0, 1'b0,  1,  0,  0, 0,   0,  3};

    // Reset state, observed before any clock edge
    #1;
    chk("rst_busy0", int'(busy0), 0);
    chk("rst_done0", int'(done0), 0);
    chk("rst_err0", int'(err0), 0);
    chk("rst_rem0", int'(rem0), 0);
    chk("rst_coins0", int'(q0) + int'(d0) + int'(n0), 0);
    chk("rst_busy1", int'(busy1), 0);
    chk("rst_rem1", int'(rem1), 0);
    @(negedge clk);
    reset_n = 1'b1;

    for (int i = 0; i < 15; i++) begin
      run_vec(vecs[i], $sformatf("v%0d", i));
    end

    // Reset in the middle of a 4-quarter request
    cur = 1'b0;
    @(negedge clk);
    amount = 9'd100; disp_ready = 1'b1; start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    nq = 0; cyc = 0;
    while (nq < 2 && cyc < 20) begin
      @(negedge clk);
      cyc++;
      if (q0) nq++;
    end
    chk("midrst_two_quarters", nq, 2);
    chk("midrst_rem_before", int'(rem0), 50);
    #2 reset_n = 1'b0;
    #1;
    chk("midrst_quarter_cleared", int'(q0), 0);
    chk("midrst_busy_cleared", int'(busy0), 0);
    chk("midrst_rem_cleared", int'(rem0), 0);
    chk("midrst_done_low", int'(done0), 0);
    chk("midrst_err_low", int'(err0), 0);
    @(negedge clk);
    reset_n = 1'b1;
    stray = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (q0 || d0 || n0 || done0 || busy0) stray++;
    end
    chk("midrst_no_activity", stray, 0);

    // Full stock after reset: 20 quarters then one nickel
    after_rst = '{1'b0, 505, 1'b0, 1'b0, 1'b0, 20, 0, 1, 0, 0, 23};
    run_vec(after_rst, "post_rst");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/change_dispenser.md
CHANGE_DISPENSER -- requirements
Module: change_dispenser

Parameters
REQ-001 The block SHALL have parameter INV_MAX, default 20, giving the coin count each inventory holds after reset or refill (1..255).

Interface
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port start, input, 1 bit: request to dispense amount; sampled only in IDLE.
REQ-005 The block SHALL have port amount, input, 9 bits: change to return, in cents (0..511), unsigned.
REQ-006 The block SHALL have port disp_ready, input, 1 bit: coin mechanism can accept a coin this cycle.
REQ-007 The block SHALL have port refill, input, 1 bit: reload all inventories to INV_MAX; honoured only in IDLE.
REQ-008 The block SHALL have ports quarter_out, dime_out and nickel_out, outputs, 1 bit each: one-cycle pulse releasing one coin of that kind.
REQ-009 The block SHALL have port busy, output, 1 bit: high whenever state is not IDLE.
REQ-010 The block SHALL have port done, output, 1 bit: one-cycle pulse at the end of every accepted request.
REQ-011 The block SHALL have port err, output, 1 bit: last request failed; held until the next accepted start.
REQ-012 The block SHALL have port remaining, output, 9 bits: cents not yet dispensed.

Function
REQ-013 The FSM SHALL have the states IDLE, DISP, DONE.
REQ-014 IDLE with start=1 at an edge: remaining<=amount, err<=0; if amount%5!=0, err<=1 and state<=DONE (no coins); otherwise state<=DISP.
REQ-015 DISP, remaining>0, disp_ready=1 at an edge: the block SHALL select a coin greedily:
  - quarter if remaining>=25 and inv_q>0;
  - else dime if remaining>=10 and inv_d>0;
  - else nickel if inv_n>0.
REQ-016 On that same edge, the block SHALL set the chosen *_out to 1 for the following cycle only, subtract the coin value from remaining, and decrement that coin's inventory.
REQ-017 DISP with disp_ready=0 SHALL change nothing and keep all *_out at 0; at most one *_out SHALL be high in any cycle.
REQ-018 DISP, remaining>0, disp_ready=1 and no eligible coin: the block SHALL set err<=1 and state<=DONE, with remaining frozen at the undispensed value.
REQ-019 DISP, remaining==0: the block SHALL set state<=DONE at the next edge regardless of disp_ready.
REQ-020 DONE: done=1 for exactly one cycle, then state<=IDLE; after an amount=0 request, done SHALL follow 2 edges after start with no coins.
REQ-021 The block SHALL ignore start while busy=1 and SHALL ignore refill while busy=1.
REQ-022 If start and refill are both high in IDLE, the block SHALL apply both on the same edge, so dispensing uses refilled inventory.
REQ-023 Greedy selection SHALL NOT backtrack: a fault is legal even where another coin mix would succeed (e.g. 30 cents, no nickels: quarter then fault, remaining=5).
REQ-024 Inventories SHALL be 8-bit counters that never decrement below 0.
REQ-025 With disp_ready held high, latency from the start edge to the done pulse SHALL be N+2 cycles, where N is the number of coins dispensed.

Reset
REQ-026 reset_n=0 SHALL immediately force state IDLE, all *_out=0, busy=0, done=0, err=0, remaining=0 and all inventories=INV_MAX, regardless of clk.
REQ-027 A reset asserted mid-dispense SHALL abort the request with no further coins and no done pulse.

Verification
REQ-028 amount=100, disp_ready=1, full stock -> 4 quarter_out pulses on consecutive cycles, remaining 75/50/25/0, done one cycle later, err=0.
REQ-029 amount=40, disp_ready toggling 1/0 -> quarter, dime, nickel, each pulse only after an edge with disp_ready=1; done after remaining=0.
REQ-030 amount=47 -> no coins, err=1, done 1 cycle after start, remaining=47.
REQ-031 INV_MAX=1, amount=65 -> quarter, dime, nickel, then fault: err=1, remaining=25; refill then amount=25 -> one quarter, err=0.
REQ-032 start pulsed during DISP with amount=200 -> ignored; original request completes unchanged.
REQ-033 reset_n low after 2 of 4 coins -> outputs cleared asynchronously, no done, inventories=INV_MAX.
